// File: rtl/vec_burst_addr_gen_if.sv
// Handshake and bus bundle between a vector burst requester and the
// address generator: request fields in, memory address stream out.
interface vec_burst_addr_gen_if #(
    parameter int ADDR_W   = 19,
    parameter int LEN_W    = 5,
    parameter int STRIDE_W = 8
);
    logic                start;
    logic                is_write;
    logic [ADDR_W-1:0]   base_addr;
    logic [STRIDE_W-1:0] stride;
    logic [LEN_W-1:0]    burst_len;
    logic [ADDR_W-1:0]   scalar_addr;
    logic                stall;
    logic                abort;

    logic [ADDR_W-1:0]   addr_out;
    logic                addr_valid;
    logic                we_out;
    logic [LEN_W-1:0]    elem_idx;
    logic                busy;
    logic                done;

    modport master (
        output start, is_write, base_addr, stride, burst_len, scalar_addr, stall, abort,
        input  addr_out, addr_valid, we_out, elem_idx, busy, done
    );

    modport slave (
        input  start, is_write, base_addr, stride, burst_len, scalar_addr, stall, abort,
        output addr_out, addr_valid, we_out, elem_idx, busy, done
    );
endinterface

// File: rtl/vec_burst_addr_gen.sv
// Vector burst address generator: latches base/stride/length/direction on
// start and walks one element address per unstalled cycle, then pulses done.
// State advances on the falling clock edge; the scalar address passes
// straight through whenever no burst is active.
module vec_burst_addr_gen #(
    parameter int ADDR_W   = 19,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = 5,
    parameter int STRIDE_W = 8
) (
    input  logic clk,
    input  logic rst,
    vec_burst_addr_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_reg, addr_nxt;
    logic [ADDR_W-1:0]   stride_reg, stride_nxt;
    logic [LEN_W-1:0]    idx, idx_nxt;
    logic [LEN_W-1:0]    len_reg, len_nxt;
    logic                wr_reg, wr_nxt;

    logic [LEN_W-1:0]    eff_len;
    logic [ADDR_W-1:0]   stride_ext;

    // Zero or oversize lengths clamp to the maximum burst; stride is sign-extended.
    always_comb begin
        eff_len = bus.burst_len;
        if (bus.burst_len == '0 || bus.burst_len > MAX_LEN_L) begin
            eff_len = MAX_LEN_L;
        end
        stride_ext = {{(ADDR_W-STRIDE_W){bus.stride[STRIDE_W-1]}}, bus.stride};
    end

    // State and datapath registers, updated on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_reg   <= '0;
            stride_reg <= '0;
            idx        <= '0;
            len_reg    <= '0;
            wr_reg     <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr_reg   <= addr_nxt;
            stride_reg <= stride_nxt;
            idx        <= idx_nxt;
            len_reg    <= len_nxt;
            wr_reg     <= wr_nxt;
        end
    end

    // Next-state and datapath update: abort beats stall beats advance.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_reg;
        stride_nxt = stride_reg;
        idx_nxt    = idx;
        len_nxt    = len_reg;
        wr_nxt     = wr_reg;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = BURST;
                    addr_nxt   = bus.base_addr;
                    stride_nxt = stride_ext;
                    wr_nxt     = bus.is_write;
                    len_nxt    = eff_len;
                    idx_nxt    = '0;
                end
            end
            BURST: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (!bus.stall) begin
                    if (idx == len_reg - LEN_W'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = idx + LEN_W'(1);
                        addr_nxt = addr_reg + stride_reg;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode; addr_out muxes in the scalar path with no added latency.
    always_comb begin
        bus.addr_out   = bus.scalar_addr;
        bus.addr_valid = 1'b0;
        bus.we_out     = 1'b0;
        bus.elem_idx   = '0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        if (state == BURST) begin
            bus.addr_out   = addr_reg;
            bus.addr_valid = 1'b1;
            bus.we_out     = wr_reg;
            bus.elem_idx   = idx;
            bus.busy       = 1'b1;
        end else if (state == DONE) begin
            bus.done = 1'b1;
        end
    end

endmodule

// File: doc/vec_burst_addr_gen.md
Name: vec_burst_addr_gen

Overview:
- Parametrised address generator for vector load/store bursts between the vector register file and data memory.
- On a start request it latches a base address, signed stride, element count and direction.
- It then issues one element address per non-stalled cycle, with element index, write strobe, busy and a one-cycle done pulse.
- When idle, the scalar address passes straight through to memory.

Parameters:
- ADDR_W, 19, memory address width.
- MAX_LEN, 16, maximum elements per burst.
- LEN_W, 5, width of burst_len and elem_idx; must satisfy 2^LEN_W > MAX_LEN.
- STRIDE_W, 8, width of the signed element stride.

Ports:
- clk, input, 1, clock; all state updates on the falling edge.
- rst, input, 1, reset: asynchronous, active-high.
- start, input, 1, burst request; sampled only in IDLE.
- is_write, input, 1, burst direction (1 = store, 0 = load); latched at start.
- base_addr, input, ADDR_W, first element address; latched at start.
- stride, input, STRIDE_W, signed two's-complement address step; latched at start.
- burst_len, input, LEN_W, element count; 0 means MAX_LEN; latched at start.
- scalar_addr, input, ADDR_W, scalar-path address forwarded when not bursting.
- stall, input, 1, memory not ready; holds the current element.
- abort, input, 1, synchronous burst cancel.
- addr_out, output, ADDR_W, memory address.
- addr_valid, output, 1, addr_out is a burst element address.
- we_out, output, 1, write strobe for the current element.
- elem_idx, output, LEN_W, index of the current element (0-based).
- busy, output, 1, burst in progress.
- done, output, 1, one-cycle pulse at burst completion.

Behaviour:
- States: IDLE, BURST, DONE; encoded register updated on falling clk edge.
- Reset (rst=1, any time, including mid-burst):
  - state=IDLE, addr_reg=0, idx=0, len_reg=0, wr_reg=0, stride_reg=0.
  - Outputs: addr_valid=0, we_out=0, busy=0, done=0, elem_idx=0, addr_out=scalar_addr.
- IDLE:
  - start=1 at an edge: addr_reg<=base_addr, stride_reg<=sign-extended stride, wr_reg<=is_write, state<=BURST.
  - len_reg<=eff_len, where eff_len = MAX_LEN if burst_len==0 or burst_len>MAX_LEN, else burst_len.
  - idx<=0.
  - start=0: remain in IDLE.
- BURST:
  - Outputs: addr_valid=1, busy=1, we_out=wr_reg, elem_idx=idx, addr_out=addr_reg.
  - Priority at each edge: rst > abort > stall > advance.
  - abort=1: state<=IDLE, no done pulse, idx<=0.
  - stall=1 (abort=0): hold all state; same address presented again.
  - Advance with idx==len_reg-1: state<=DONE.
  - Advance otherwise: idx<=idx+1, addr_reg<=addr_reg+stride_reg, modulo 2^ADDR_W (wraps silently, no error flag).
  - An unstalled burst of N elements occupies exactly N BURST cycles.
- DONE:
  - done=1, busy=0, addr_valid=0, we_out=0; lasts exactly one cycle, then IDLE.
  - start is ignored in DONE; the minimum start-to-start spacing is N+2 cycles.
- start while BURST or DONE: ignored, not queued.
- Input-change rule: is_write, base_addr, stride and burst_len changes during BURST have no effect.
- addr_out is a combinational mux: addr_reg when state==BURST, scalar_addr otherwise. There is no added latency on the scalar path.
- Latency: start sampled at edge k; first element address valid after edge k; done asserted after edge k+N (no stalls).
- All arithmetic is unsigned modulo 2^ADDR_W after stride sign-extension. idx never exceeds MAX_LEN-1.

Test Plan:
- Basic load: base 0x00100, stride 1, len 16, is_write=0 -> addr_out 0x00100..0x0010F on 16 consecutive cycles, elem_idx 0..15, we_out=0, then done=1 for one cycle, then addr_out=scalar_addr.
- Negative stride store: base 0x00020, stride -4 (0xFC), len 4, is_write=1 -> 0x00020, 0x0001C, 0x00018, 0x00014 with we_out=1, done after 4 cycles.
- Wrap and length clamp:
  - base 0x7FFFE, stride 1, len 4 -> 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
  - burst_len 0 -> 16 elements.
  - burst_len 20 -> 16 elements.
- Stall: base 0x00040, stride 2, len 3, stall=1 for 2 cycles while elem_idx=1 -> 0x00040 once, 0x00042 three cycles, 0x00044 once, done after 5 BURST cycles.
- Abort/reset mid-burst:
  - abort at elem_idx=5 -> IDLE next edge, no done, addr_out=scalar_addr.
  - Async rst asserted between edges -> outputs reset immediately.
  - New start is then accepted normally.
- Start while busy: second start pulse at elem_idx=3 of a len-8 burst -> ignored, exactly 8 addresses and one done pulse.
